// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
// SPI mode-0 controller that serialises 16-bit register-write frames
// {rw, addr[6:0], data[7:0]} MSB first onto cs_n/sclk/copi. sclk is derived
// from clk (CLK_DIV clk cycles per half period) so copi is always stable for a
// full half period around every rising sclk edge.
//
// Parameters:
//   CLK_DIV   - clk cycles per sclk half period (2..255)
//   LEAD_CLKS - dummy sclk pulses (copi=0) before frame bit15 (0..3)
//   CS_GAP    - minimum clk cycles cs_n stays high between frames (>=1)
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   req_valid/ready - request handshake (ready high only in IDLE)
//   req_rw/addr/data- frame fields latched on accept
//   busy            - high from acceptance until return to IDLE
//   done            - one-cycle pulse on re-entering IDLE after a frame
//   cs_n/sclk/copi  - SPI bus (sclk idles low)
//
// Build option:
//   SPI_CTRL_TRAIL_CLK_EN - adds 2 trailing sclk pulses with cs_n high after
//                           each frame so the peripheral's sclk-clocked logic
//                           can advance.
// -----------------------------------------------------------------------------
module spi_controller #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned LEAD_CLKS = 0,
    parameter int unsigned CS_GAP    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       sclk,
    output logic       copi
);

    localparam int unsigned N_BITS = LEAD_CLKS + 16;
    localparam int unsigned GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [7:0]       HALF_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0]       BIT_LAST  = 5'(N_BITS - 1);
    localparam logic [5:0]       LEAD_N    = 6'(LEAD_CLKS);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
`ifdef SPI_CTRL_TRAIL_CLK_EN
        ST_TRAIL,
`endif
        ST_GAP
    } state_t;

    state_t             r_state;
    logic [7:0]         r_half_cnt;
    logic [4:0]         r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [15:0]        r_shift;
    logic               r_cs_n;
    logic               r_sclk;
    logic               r_copi;
    logic               r_busy;
    logic               r_done;
    logic               r_ready;

    state_t             w_state;
    logic [7:0]         w_half_cnt;
    logic [4:0]         w_bit_cnt;
    logic [GAP_W-1:0]   w_gap_cnt;
    logic [15:0]        w_shift;
    logic               w_cs_n;
    logic               w_sclk;
    logic               w_copi;
    logic               w_busy;
    logic               w_done;
    logic               w_ready;

    logic               w_half_last;
    logic [4:0]         w_next_bit;
    logic               w_next_is_frame;

    assign w_half_last = (r_half_cnt == HALF_LAST);
    assign w_next_bit  = r_bit_cnt + 5'd1;
    // Next bit index >= LEAD_CLKS, i.e. it carries a real frame bit.
    assign w_next_is_frame = ((6'(w_next_bit) + 6'd1) > LEAD_N);

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_half_cnt <= 8'd0;
            r_bit_cnt  <= 5'd0;
            r_gap_cnt  <= '0;
            r_shift    <= 16'd0;
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_copi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_half_cnt <= w_half_cnt;
            r_bit_cnt  <= w_bit_cnt;
            r_gap_cnt  <= w_gap_cnt;
            r_shift    <= w_shift;
            r_cs_n     <= w_cs_n;
            r_sclk     <= w_sclk;
            r_copi     <= w_copi;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_ready    <= w_ready;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state    = r_state;
        w_half_cnt = r_half_cnt;
        w_bit_cnt  = r_bit_cnt;
        w_gap_cnt  = r_gap_cnt;
        w_shift    = r_shift;
        w_cs_n     = r_cs_n;
        w_sclk     = r_sclk;
        w_copi     = r_copi;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_ready    = r_ready;

        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_ready) begin
                    w_state    = ST_SETUP;
                    w_half_cnt = 8'd0;
                    w_bit_cnt  = 5'd0;
                    w_cs_n     = 1'b0;
                    w_busy     = 1'b1;
                    w_ready    = 1'b0;
                    // Bit 0 is either frame bit15 or a dummy lead bit.
                    if (LEAD_CLKS == 0) begin
                        w_copi  = req_rw;
                        w_shift = {req_addr, req_data, 1'b0};
                    end else begin
                        w_copi  = 1'b0;
                        w_shift = {req_rw, req_addr, req_data};
                    end
                end
            end

            ST_SETUP: begin
                if (w_half_last) begin
                    w_state    = ST_SHIFT;
                    w_half_cnt = 8'd0;
                    w_sclk     = 1'b1;
                end else begin
                    w_half_cnt = r_half_cnt + 8'd1;
                end
            end

            ST_SHIFT: begin
                if (!w_half_last) begin
                    w_half_cnt = r_half_cnt + 8'd1;
                end else begin
                    w_half_cnt = 8'd0;
                    if (r_sclk) begin
                        // Falling edge: the only place copi is allowed to move.
                        w_sclk = 1'b0;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state = ST_HOLD;
                            w_copi  = 1'b0;
                        end else begin
                            w_bit_cnt = w_next_bit;
                            if (w_next_is_frame) begin
                                w_copi  = r_shift[15];
                                w_shift = {r_shift[14:0], 1'b0};
                            end else begin
                                w_copi  = 1'b0;
                            end
                        end
                    end else begin
                        w_sclk = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (w_half_last) begin
                    w_half_cnt = 8'd0;
                    w_cs_n     = 1'b1;
`ifdef SPI_CTRL_TRAIL_CLK_EN
                    w_state    = ST_TRAIL;
                    w_sclk     = 1'b1;
                    w_bit_cnt  = 5'd0;
`else
                    w_state    = ST_GAP;
                    w_gap_cnt  = '0;
`endif
                end else begin
                    w_half_cnt = r_half_cnt + 8'd1;
                end
            end

`ifdef SPI_CTRL_TRAIL_CLK_EN
            // Two free-running sclk pulses with cs_n high; bit counter counts pulses.
            ST_TRAIL: begin
                if (!w_half_last) begin
                    w_half_cnt = r_half_cnt + 8'd1;
                end else begin
                    w_half_cnt = 8'd0;
                    if (r_sclk) begin
                        w_sclk = 1'b0;
                    end else if (r_bit_cnt == 5'd1) begin
                        w_state   = ST_GAP;
                        w_gap_cnt = '0;
                    end else begin
                        w_sclk    = 1'b1;
                        w_bit_cnt = w_next_bit;
                    end
                end
            end
`endif

            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state = ST_IDLE;
                    w_busy  = 1'b0;
                    w_ready = 1'b1;
                    w_done  = 1'b1;
                end else begin
                    w_gap_cnt = r_gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_cs_n  = 1'b1;
                w_sclk  = 1'b0;
                w_copi  = 1'b0;
                w_busy  = 1'b0;
                w_ready = 1'b1;
            end
        endcase
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cs_n      = r_cs_n;
    assign sclk      = r_sclk;
    assign copi      = r_copi;

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
// Directed bench for spi_controller. Instance u_dut_a uses default parameters
// and is observed by a small peripheral model (bit capture, register bank,
// copi-stability watch). Instance u_dut_b uses CLK_DIV=2, LEAD_CLKS=1.
// Cycle numbers count clk cycles after the accept edge (cycle 1 is the first
// cycle showing the accepted frame).
// -----------------------------------------------------------------------------
module tb_spi_controller;

    localparam int CS_GAP = 4;
    localparam int LIMIT  = 400;
`ifdef SPI_CTRL_TRAIL_CLK_EN
    localparam int TRAIL_CYC  = 16;
    localparam int EXP_TRAIL  = 2;
    localparam int EXP_DONE   = 153;
    localparam int EXP_DONE_B = 83;
`else
    localparam int TRAIL_CYC  = 0;
    localparam int EXP_TRAIL  = 0;
    localparam int EXP_DONE   = 137;
    localparam int EXP_DONE_B = 75;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_req_valid, a_req_ready, a_req_rw, a_busy, a_done, a_cs_n, a_sclk, a_copi;
    logic [6:0] a_req_addr;
    logic [7:0] a_req_data;
    logic       b_req_valid, b_req_ready, b_req_rw, b_busy, b_done, b_cs_n, b_sclk, b_copi;
    logic [6:0] b_req_addr;
    logic [7:0] b_req_data;

    int checks = 0;
    int errors = 0;

    spi_controller u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_rw(a_req_rw), .req_addr(a_req_addr), .req_data(a_req_data),
        .busy(a_busy), .done(a_done),
        .cs_n(a_cs_n), .sclk(a_sclk), .copi(a_copi)
    );

    spi_controller #(.CLK_DIV(2), .LEAD_CLKS(1), .CS_GAP(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_rw(b_req_rw), .req_addr(b_req_addr), .req_data(b_req_data),
        .busy(b_busy), .done(b_done),
        .cs_n(b_cs_n), .sclk(b_sclk), .copi(b_copi)
    );

    // Peripheral model for u_dut_a.
    logic        m_sclk_q = 1'b0;
    logic        m_cs_q   = 1'b1;
    logic        m_copi_q = 1'b0;
    logic [15:0] m_rx     = 16'd0;
    logic [15:0] m_frame  = 16'd0;
    int          m_rx_cnt = 0;
    int          m_frame_bits = 0;
    int          m_trail_rises = 0;
    int          m_idle_copi_bad = 0;
    int          m_copi_viol = 0;
    logic [7:0]  m_regs [0:127];

    always @(negedge clk) begin
        if (m_cs_q === 1'b1 && a_cs_n === 1'b0) m_rx_cnt = 0;
        if (m_sclk_q === 1'b0 && a_sclk === 1'b1) begin
            if (a_cs_n === 1'b0) begin
                m_rx = {m_rx[14:0], a_copi};
                m_rx_cnt++;
            end else begin
                m_trail_rises++;
            end
        end
        if (a_cs_n === 1'b1 && a_copi !== 1'b0) m_idle_copi_bad++;
        if (a_sclk === 1'b1 && a_copi !== m_copi_q) m_copi_viol++;
        if (m_cs_q === 1'b0 && a_cs_n === 1'b1) begin
            m_frame      = m_rx;
            m_frame_bits = m_rx_cnt;
            if (m_rx_cnt == 16 && m_rx[15]) m_regs[m_rx[14:8]] = m_rx[7:0];
        end
        m_sclk_q = a_sclk;
        m_cs_q   = a_cs_n;
        m_copi_q = a_copi;
    end

    // Issue one frame on u_dut_a and return timing observations.
    task automatic run_frame_a(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                               output int done_cyc, output int cs_fall, output int cs_rise,
                               output int cs_low);
        int c;
        done_cyc = -1; cs_fall = -1; cs_rise = -1; cs_low = 0; c = 0;
        for (int i = 0; i < LIMIT && a_req_ready !== 1'b1; i++) begin
            @(negedge clk); #1;
        end
        a_req_valid = 1'b1; a_req_rw = rw; a_req_addr = addr; a_req_data = data;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        while (done_cyc < 0 && c < LIMIT) begin
            @(negedge clk); #1;
            c++;
            if (a_cs_n === 1'b0) begin
                cs_low++;
                if (cs_fall < 0) cs_fall = c;
            end else if (cs_fall >= 0 && cs_rise < 0) begin
                cs_rise = c;
            end
            if (a_done === 1'b1) done_cyc = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (a_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", a_cs_n); end
        checks++; if (a_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", a_sclk); end
        checks++; if (a_copi !== 1'b0) begin errors++; $display("FAIL reset_copi: got %b expected 0", a_copi); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", a_done); end
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", a_req_ready); end
        checks++; if (b_cs_n !== 1'b1 || b_req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_b: cs_n=%b ready=%b expected 1 1", b_cs_n, b_req_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        int d, f, r, lo, tr0, vi0, ic0;
        tr0 = m_trail_rises; vi0 = m_copi_viol; ic0 = m_idle_copi_bad;
        run_frame_a(1'b1, 7'h00, 8'hA5, d, f, r, lo);
        checks++; if (f != 1) begin errors++; $display("FAIL single_cs_fall: got %0d expected 1", f); end
        checks++; if (lo != 132) begin errors++; $display("FAIL single_cs_low: got %0d expected 132", lo); end
        checks++; if (r != 133) begin errors++; $display("FAIL single_cs_rise: got %0d expected 133", r); end
        checks++; if (d != EXP_DONE) begin errors++; $display("FAIL single_done: got %0d expected %0d", d, EXP_DONE); end
        checks++; if (m_frame !== 16'h80A5 || m_frame_bits != 16) begin
            errors++; $display("FAIL single_bits: got %h/%0d expected 80a5/16", m_frame, m_frame_bits);
        end
        checks++; if (m_regs[0] !== 8'hA5) begin errors++; $display("FAIL single_reg0: got %h expected a5", m_regs[0]); end
        checks++; if (m_trail_rises - tr0 != EXP_TRAIL) begin
            errors++; $display("FAIL single_trail: got %0d expected %0d", m_trail_rises - tr0, EXP_TRAIL);
        end
        checks++; if (m_idle_copi_bad != ic0 || m_copi_viol != vi0) begin
            errors++; $display("FAIL single_copi: idle_bad=%0d viol=%0d expected 0 0", m_idle_copi_bad - ic0, m_copi_viol - vi0);
        end
    endtask

    task automatic test_read_frame();
        int d, f, r, lo;
        run_frame_a(1'b0, 7'h01, 8'h33, d, f, r, lo);
        checks++; if (m_frame !== 16'h0133) begin errors++; $display("FAIL rw0_bits: got %h expected 0133", m_frame); end
        checks++; if (d != EXP_DONE) begin errors++; $display("FAIL rw0_done: got %0d expected %0d", d, EXP_DONE); end
        checks++; if (m_regs[1] !== 8'h00) begin errors++; $display("FAIL rw0_reg1: got %h expected 00", m_regs[1]); end
    endtask

    task automatic test_back_to_back();
        int c, d1, d2, ready_bad, gap_hi;
        logic [15:0] f1;
        c = 0; d1 = -1; d2 = -1; ready_bad = 0; gap_hi = 0;
        for (int i = 0; i < LIMIT && a_req_ready !== 1'b1; i++) begin
            @(negedge clk); #1;
        end
        a_req_valid = 1'b1; a_req_rw = 1'b1; a_req_addr = 7'h04; a_req_data = 8'h3C;
        @(posedge clk); #1;
        a_req_addr = 7'h02; a_req_data = 8'hFF;
        while (d1 < 0 && c < LIMIT) begin
            @(negedge clk); #1;
            c++;
            if (a_cs_n === 1'b1) gap_hi++;
            if (a_done === 1'b1) d1 = c;
            else if (a_req_ready !== 1'b0) ready_bad++;
        end
        f1 = m_frame;
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL b2b_ready_low: got %0d high cycles expected 0", ready_bad); end
        checks++; if (d1 != EXP_DONE) begin errors++; $display("FAIL b2b_done1: got %0d expected %0d", d1, EXP_DONE); end
        checks++; if (f1 !== 16'h843C) begin errors++; $display("FAIL b2b_bits1: got %h expected 843c", f1); end
        @(negedge clk); #1;
        // Second frame was accepted on the done cycle, so it starts here.
        checks++; if (a_cs_n !== 1'b0 || a_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept2: cs_n=%b busy=%b expected 0 1", a_cs_n, a_busy);
        end
        // GAP cycles plus the done/accept cycle in IDLE (plus trailing pulses).
        checks++; if (gap_hi != CS_GAP + 1 + TRAIL_CYC) begin
            errors++; $display("FAIL b2b_cs_high: got %0d expected %0d", gap_hi, CS_GAP + 1 + TRAIL_CYC);
        end
        a_req_valid = 1'b0;
        c = 1;
        while (d2 < 0 && c < LIMIT) begin
            @(negedge clk); #1;
            c++;
            if (a_done === 1'b1) d2 = c;
        end
        checks++; if (d2 != EXP_DONE) begin errors++; $display("FAIL b2b_done2: got %0d expected %0d", d2, EXP_DONE); end
        checks++; if (m_frame !== 16'h82FF) begin errors++; $display("FAIL b2b_bits2: got %h expected 82ff", m_frame); end
        checks++; if (m_regs[4] !== 8'h3C || m_regs[2] !== 8'hFF) begin
            errors++; $display("FAIL b2b_regs: got %h %h expected 3c ff", m_regs[4], m_regs[2]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int rises, c, done_seen, d, f, r, lo;
        logic prev;
        rises = 0; c = 0; done_seen = 0; prev = 1'b0;
        for (int i = 0; i < LIMIT && a_req_ready !== 1'b1; i++) begin
            @(negedge clk); #1;
        end
        a_req_valid = 1'b1; a_req_rw = 1'b1; a_req_addr = 7'h06; a_req_data = 8'h99;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        while (rises < 7 && c < LIMIT) begin
            @(negedge clk); #1;
            c++;
            if (a_sclk === 1'b1 && prev === 1'b0) rises++;
            prev = a_sclk;
        end
        checks++; if (rises != 7) begin errors++; $display("FAIL mid_rises: got %0d expected 7", rises); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (a_cs_n !== 1'b1 || a_sclk !== 1'b0 || a_copi !== 1'b0) begin
            errors++; $display("FAIL mid_bus: cs_n=%b sclk=%b copi=%b expected 1 0 0", a_cs_n, a_sclk, a_copi);
        end
        checks++; if (a_busy !== 1'b0 || a_req_ready !== 1'b1 || a_done !== 1'b0) begin
            errors++; $display("FAIL mid_ctrl: busy=%b ready=%b done=%b expected 0 1 0", a_busy, a_req_ready, a_done);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (a_done === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_seen); end
        checks++; if (m_frame_bits != 7 || m_regs[6] !== 8'h00) begin
            errors++; $display("FAIL mid_partial: bits=%0d reg6=%h expected 7 00", m_frame_bits, m_regs[6]);
        end
        run_frame_a(1'b1, 7'h05, 8'h5A, d, f, r, lo);
        checks++; if (m_frame !== 16'h855A || d != EXP_DONE) begin
            errors++; $display("FAIL mid_fresh: bits=%h done=%0d expected 855a %0d", m_frame, d, EXP_DONE);
        end
        checks++; if (m_regs[5] !== 8'h5A) begin errors++; $display("FAIL mid_reg5: got %h expected 5a", m_regs[5]); end
    endtask

    task automatic test_lead_clk();
        int c, d, nr, run, bad_phase, cs_low;
        logic prev_s, ended;
        logic [16:0] bits;
        c = 0; d = -1; nr = 0; run = 0; bad_phase = 0; cs_low = 0;
        prev_s = 1'b0; ended = 1'b0; bits = 17'd0;
        for (int i = 0; i < LIMIT && b_req_ready !== 1'b1; i++) begin
            @(negedge clk); #1;
        end
        b_req_valid = 1'b1; b_req_rw = 1'b1; b_req_addr = 7'h03; b_req_data = 8'h81;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        while (d < 0 && c < LIMIT) begin
            @(negedge clk); #1;
            c++;
            if (b_cs_n === 1'b0) begin
                cs_low++;
                if (b_sclk === 1'b1 && prev_s === 1'b0) begin
                    bits = {bits[15:0], b_copi};
                    nr++;
                end
                if (b_sclk === prev_s) run++;
                else begin
                    if (run != 2) bad_phase++;
                    run = 1;
                end
            end else if (!ended && cs_low > 0) begin
                if (run != 2) bad_phase++;
                ended = 1'b1;
            end
            prev_s = b_sclk;
            if (b_done === 1'b1) d = c;
        end
        checks++; if (nr != 17) begin errors++; $display("FAIL lead_rises: got %0d expected 17", nr); end
        checks++; if (bits !== 17'h08381) begin errors++; $display("FAIL lead_bits: got %h expected 08381", bits); end
        checks++; if (bad_phase != 0) begin errors++; $display("FAIL lead_phase: got %0d bad phases expected 0", bad_phase); end
        checks++; if (cs_low != 70) begin errors++; $display("FAIL lead_cs_low: got %0d expected 70", cs_low); end
        checks++; if (d != EXP_DONE_B) begin errors++; $display("FAIL lead_done: got %0d expected %0d", d, EXP_DONE_B); end
    endtask

    task automatic test_random_copi_stable();
        int d, f, r, lo, bad, vi0, ic0;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        bad = 0; vi0 = m_copi_viol; ic0 = m_idle_copi_bad;
        for (int i = 0; i < 100; i++) begin
            rw   = 1'($urandom_range(0, 1));
            addr = 7'($urandom_range(0, 127));
            data = 8'($urandom_range(0, 255));
            run_frame_a(rw, addr, data, d, f, r, lo);
            if (m_frame !== {rw, addr, data} || m_frame_bits != 16 || d != EXP_DONE) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_frames: got %0d bad frames expected 0", bad); end
        checks++; if (m_copi_viol != vi0) begin
            errors++; $display("FAIL rand_copi_stable: got %0d changes while sclk high expected 0", m_copi_viol - vi0);
        end
        checks++; if (m_idle_copi_bad != ic0) begin
            errors++; $display("FAIL rand_copi_idle: got %0d cycles expected 0", m_idle_copi_bad - ic0);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_rw = 1'b0; a_req_addr = 7'h00; a_req_data = 8'h00;
        b_req_valid = 1'b0; b_req_rw = 1'b0; b_req_addr = 7'h00; b_req_data = 8'h00;
        test_reset();
        test_single_write();
        test_read_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_lead_clk();
        test_random_copi_stable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
